// File: rtl/mult_final_adder_pkg.sv
// Shared sizing constants for the multiplier datapath. The compressor and the
// partial-product generator use the same values.
package mult_final_adder_pkg;

    localparam int MULT_WIDTH = 32;
    localparam int MULT_SPLIT = 16;
    localparam int MULT_TAG_W = 4;

endpackage

// File: rtl/mult_final_adder_if.sv
// Handshake bus of the final adder. The compressor side is in_*, and the
// result-register side is out_*. The master drives beats in and takes results out.
interface mult_final_adder_if
    import mult_final_adder_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH,
    parameter int TAG_W = MULT_TAG_W
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_sum;
    logic [WIDTH-1:0] in_carry;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_product;
    logic [TAG_W-1:0] out_tag;
    logic             out_ovf;

    modport master (
        output in_valid, in_sum, in_carry, in_tag, out_ready,
        input  in_ready, out_valid, out_product, out_tag, out_ovf
    );

    modport slave (
        input  in_valid, in_sum, in_carry, in_tag, out_ready,
        output in_ready, out_valid, out_product, out_tag, out_ovf
    );
endinterface

// File: rtl/mult_final_adder_cpa_adder.sv
// Purely combinational N-bit carry-propagate adder: {cout, sum} = a + b + cin.
module cpa_adder #(
    parameter int N = 16
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         cin_i,
    output logic [N-1:0] sum_o,
    output logic         cout_o
);
    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{N{1'b0}}, cin_i};
endmodule

// File: rtl/mult_final_adder.sv
// Final carry-propagate stage of the multiplier. It resolves the Sum/Carry pair
// into one binary product over two pipeline stages. Stage 1 adds the low half and
// holds the high halves. Stage 2 adds the high half with the mid carry. Both
// sides use valid/ready, and the pipeline sustains one beat per cycle.
module mult_final_adder
    import mult_final_adder_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH,
    parameter int SPLIT = MULT_SPLIT,
    parameter int TAG_W = MULT_TAG_W
) (
    input  logic               clk,
    input  logic               rst_n,
    mult_final_adder_if.slave  bus
);
    localparam int HI_W = WIDTH - SPLIT;

    logic             s1_valid_q, s1_valid_d;
    logic             s2_valid_q, s2_valid_d;
    logic [SPLIT:0]   s1_lo_q;
    logic [HI_W-1:0]  s1_hi_s_q;
    logic [HI_W-1:0]  s1_hi_c_q;
    logic [TAG_W-1:0] s1_tag_q;
    logic [WIDTH-1:0] out_product_q;
    logic [TAG_W-1:0] out_tag_q;
    logic             out_ovf_q;

    logic             s1_load;
    logic             s2_adv;
    logic [SPLIT-1:0] lo_sum;
    logic             lo_cout;
    logic [HI_W-1:0]  hi_sum;
    logic             hi_cout;

    // Low half is added straight off the input bus, so its carry is registered with it.
    cpa_adder #(.N(SPLIT)) u_lo_add (
        .a_i    (bus.in_sum[SPLIT-1:0]),
        .b_i    (bus.in_carry[SPLIT-1:0]),
        .cin_i  (1'b0),
        .sum_o  (lo_sum),
        .cout_o (lo_cout)
    );

    // High half consumes the held upper bits plus the registered mid carry.
    cpa_adder #(.N(HI_W)) u_hi_add (
        .a_i    (s1_hi_s_q),
        .b_i    (s1_hi_c_q),
        .cin_i  (s1_lo_q[SPLIT]),
        .sum_o  (hi_sum),
        .cout_o (hi_cout)
    );

    // Handshake: stage 2 takes stage 1's beat when it is empty or draining this
    // cycle. Stage 1 accepts whenever it will be vacant after this edge.
    always_comb begin
        s2_adv     = s1_valid_q && (!s2_valid_q || bus.out_ready);
        s1_load    = bus.in_valid && (!s1_valid_q || s2_adv);
        s1_valid_d = s1_load ? 1'b1 : (s2_adv ? 1'b0 : s1_valid_q);
        s2_valid_d = s2_adv ? 1'b1 : (bus.out_ready ? 1'b0 : s2_valid_q);
    end

    assign bus.in_ready    = !s1_valid_q || s2_adv;
    assign bus.out_valid   = s2_valid_q;
    assign bus.out_product = out_product_q;
    assign bus.out_tag     = out_tag_q;
    assign bus.out_ovf     = out_ovf_q;

    // Stage occupancy flags; reset discards any in-flight beats immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
        end
    end

    // Stage 1 holding registers; they change only when a new beat is accepted.
    always_ff @(posedge clk) begin
        if (s1_load) begin
            s1_lo_q   <= {lo_cout, lo_sum};
            s1_hi_s_q <= bus.in_sum[WIDTH-1:SPLIT];
            s1_hi_c_q <= bus.in_carry[WIDTH-1:SPLIT];
            s1_tag_q  <= bus.in_tag;
        end
    end

    // Stage 2 result registers. They are cleared on reset and held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_product_q <= '0;
            out_tag_q     <= '0;
            out_ovf_q     <= 1'b0;
        end else if (s2_adv) begin
            out_product_q <= {hi_sum, s1_lo_q[SPLIT-1:0]};
            out_tag_q     <= s1_tag_q;
            out_ovf_q     <= hi_cout;
        end
    end
endmodule

// File: tb/tb_mult_final_adder.sv
module tb_mult_final_adder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mult_final_adder_if #(.WIDTH(32), .TAG_W(4)) bus ();

    mult_final_adder #(.WIDTH(32), .SPLIT(16), .TAG_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference: each in-flight beat carries its final answer and the number of
    // edges since it was accepted; a beat is visible at the output from its
    // second edge on, provided it is the oldest.
    typedef struct {
        logic [31:0] prod;
        logic [3:0]  tag;
        logic        ovf;
        int          age;
    } beat_t;
    beat_t q[$];

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic cycle(input logic v, input logic [31:0] s, input logic [31:0] c,
                         input logic [3:0] t, input logic r, output logic acc);
        logic        exp_rdy;
        logic        exp_ov;
        logic [32:0] full;
        beat_t       nb;
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_sum    = s;
        bus.in_carry  = c;
        bus.in_tag    = t;
        bus.out_ready = r;
        #1;
        exp_ov  = (q.size() > 0) && (q[0].age >= 2);
        exp_rdy = !(q.size() == 2 && !r);
        chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
        chk("out_valid", 64'(bus.out_valid), 64'(exp_ov));
        if (exp_ov) begin
            chk("product", 64'(bus.out_product), 64'(q[0].prod));
            chk("tag", 64'(bus.out_tag), 64'(q[0].tag));
            chk("ovf", 64'(bus.out_ovf), 64'(q[0].ovf));
        end
        acc = v && exp_rdy;
        @(posedge clk);
        if (exp_ov && r) void'(q.pop_front());
        foreach (q[i]) q[i].age++;
        if (acc) begin
            full    = {1'b0, s} + {1'b0, c};
            nb.prod = full[31:0];
            nb.tag  = t;
            nb.ovf  = full[32];
            nb.age  = 1;
            q.push_back(nb);
        end
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, a);
    endtask

    initial begin
        logic        a;
        int          n_acc;
        int          cyc;
        logic        hold_v;
        logic [31:0] hs, hc;
        logic [3:0]  ht;

        bus.in_valid = 1'b0; bus.in_sum = '0; bus.in_carry = '0; bus.in_tag = '0;
        bus.out_ready = 1'b1;
        #12;
        chk("rst_out_valid", 64'(bus.out_valid), 64'h0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'h1);
        chk("rst_product", 64'(bus.out_product), 64'h0);
        chk("rst_tag", 64'(bus.out_tag), 64'h0);
        chk("rst_ovf", 64'(bus.out_ovf), 64'h0);
        @(negedge clk); rst_n = 1'b1;

        // Basic cross-split carry
        cycle(1'b1, 32'h0000_FFFF, 32'h0000_0001, 4'd3, 1'b1, a);
        idle(1);
        #2;
        chk("basic_valid", 64'(bus.out_valid), 64'h1);
        chk("basic_product", 64'(bus.out_product), 64'h0001_0000);
        chk("basic_tag", 64'(bus.out_tag), 64'h3);
        chk("basic_ovf", 64'(bus.out_ovf), 64'h0);
        idle(2);

        // Wrap-around
        cycle(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 4'd1, 1'b1, a);
        cycle(1'b1, 32'h8000_0000, 32'h8000_0000, 4'd2, 1'b1, a);
        #2;
        chk("wrap1_product", 64'(bus.out_product), 64'h0);
        chk("wrap1_ovf", 64'(bus.out_ovf), 64'h1);
        idle(1);
        #2;
        chk("wrap2_product", 64'(bus.out_product), 64'h0);
        chk("wrap2_ovf", 64'(bus.out_ovf), 64'h1);
        chk("wrap2_tag", 64'(bus.out_tag), 64'h2);
        idle(2);

        // Back-to-back random beats, tags cycling 0..15
        for (int i = 0; i < 100; i++)
            cycle(1'b1, $urandom, $urandom, 4'(i % 16), 1'b1, a);
        idle(3);
        chk("b2b_drained", 64'(q.size()), 64'h0);

        // Backpressure: three beats offered against a stalled consumer
        n_acc = 0;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 32'h100 + 32'(i), 32'h10, 4'(i), 1'b0, a);
            if (a) n_acc++;
        end
        chk("bp_accepted", 64'(n_acc), 64'd2);
        #2;
        chk("bp_in_ready_low", 64'(bus.in_ready), 64'h0);
        cycle(1'b1, 32'h102, 32'h10, 4'd2, 1'b1, a);
        chk("bp_release_accept", 64'(a), 64'h1);
        idle(4);

        // Random valid/ready over 10k beats, producer holds data while stalled
        n_acc = 0; cyc = 0; hold_v = 1'b0; hs = '0; hc = '0; ht = '0;
        while (n_acc < 10000 && cyc < 60000) begin
            if (!hold_v) begin
                hold_v = ($urandom_range(0, 99) >= 30);
                hs = $urandom; hc = $urandom; ht = 4'($urandom);
            end
            cycle(hold_v, hs, hc, ht, ($urandom_range(0, 99) >= 40), a);
            if (a) begin
                n_acc++;
                hold_v = 1'b0;
            end
            cyc++;
        end
        chk("rand_beats", 64'(n_acc), 64'd10000);
        idle(4);

        // Reset with both stages full
        cycle(1'b1, 32'h11, 32'h22, 4'd7, 1'b0, a);
        cycle(1'b1, 32'h33, 32'h44, 4'd8, 1'b0, a);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(bus.out_valid), 64'h0);
        chk("mid_rst_in_ready", 64'(bus.in_ready), 64'h1);
        chk("mid_rst_product", 64'(bus.out_product), 64'h0);
        q.delete();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk); rst_n = 1'b1;
        cycle(1'b1, 32'd5, 32'd7, 4'd9, 1'b1, a);
        idle(1);
        #2;
        chk("post_rst_valid", 64'(bus.out_valid), 64'h1);
        chk("post_rst_product", 64'(bus.out_product), 64'd12);
        chk("post_rst_tag", 64'(bus.out_tag), 64'h9);
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
